// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline types: datapath word, stage occupancy states and per-boundary payloads.
package pipe_stage_skid_pkg;

  typedef logic [63:0] dw;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } stage_state_e;

  typedef struct packed {
    dw alu_out;
    dw ld_data;
  } mem_wb_t;

  localparam int unsigned MemWbW = $bits(mem_wb_t);

  function automatic logic [1:0] state_occ(stage_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    unique case (s)
      StEmpty: occ = 2'd0;
      StFull:  occ = 2'd1;
      StSkid:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_stage_skid_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush and optional 1-entry skid buffer.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit SkidOn = (SKID_EN != 0);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_occ(state_q);

  // With the skid buffer, in_ready depends only on state, breaking the out_ready->in_ready path.
  always_comb begin
    if (SkidOn) begin
      in_ready = (state_q != StSkid);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = StFull;
        end
      end
      StFull: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && SkidOn) begin
          skid_d  = in_data;
          state_d = StSkid;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Data registers keep their contents; only the state is cleared.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  pipe_stage_skid_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!out_valid),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: skid instance, no-skid instance and a narrow-counter instance.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Skid-enabled, full-width instance
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [127:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic [31:0]  a_bubble;

  // No skid buffer
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;
  logic [7:0] b_bubble;

  // 4-bit bubble counter
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [1:0] c_occ;
  logic [3:0] c_bubble;

  pipe_stage_skid #(.DATA_W(128), .SKID_EN(1), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .occupancy(a_occ), .bubble_cnt(a_bubble)
  );

  pipe_stage_skid #(.DATA_W(8), .SKID_EN(0), .CNT_W(8)) u_dut_noskid (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .occupancy(b_occ), .bubble_cnt(b_bubble)
  );

  pipe_stage_skid #(.DATA_W(8), .SKID_EN(1), .CNT_W(4)) u_dut_cnt (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .occupancy(c_occ), .bubble_cnt(c_bubble)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_in_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset values, then three idle cycles
    check("rst_out_valid", 128'(a_out_valid), 128'd0);
    check("rst_occ", 128'(a_occ), 128'd0);
    check("rst_out_data", a_out_data, 128'd0);
    check("rst_in_ready", 128'(a_in_ready), 128'd1);
    check("rst_bubble", 128'(a_bubble), 128'd0);
    repeat (3) tick();
    check("idle_bubble3", 128'(a_bubble), 128'd3);

    // 2: back-to-back stream with out_ready high
    a_out_ready = 1;
    a_in_valid  = 1;
    a_in_data   = 128'h11;
    #1 check("stream_rdy0", 128'(a_in_ready), 128'd1);
    tick();
    check("stream_d11", a_out_data, 128'h11);
    check("stream_v11", 128'(a_out_valid), 128'd1);
    a_in_data = 128'h22;
    #1 check("stream_rdy1", 128'(a_in_ready), 128'd1);
    tick();
    check("stream_d22", a_out_data, 128'h22);
    a_in_data = 128'h33;
    #1 check("stream_rdy2", 128'(a_in_ready), 128'd1);
    tick();
    check("stream_d33", a_out_data, 128'h33);
    a_in_valid = 0;
    tick();
    check("stream_drained", 128'(a_out_valid), 128'd0);
    check("stream_bubble", 128'(a_bubble), 128'd4);

    // 3: fill skid with out_ready low, then drain in order
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = 128'hA;
    tick();
    check("skid_occ1", 128'(a_occ), 128'd1);
    check("skid_rdy1", 128'(a_in_ready), 128'd1);
    a_in_data = 128'hB;
    tick();
    a_in_valid = 0;
    check("skid_occ2", 128'(a_occ), 128'd2);
    check("skid_rdy0", 128'(a_in_ready), 128'd0);
    check("skid_hold_a", a_out_data, 128'hA);
    tick();
    check("skid_stable_a", a_out_data, 128'hA);
    check("skid_stable_occ", 128'(a_occ), 128'd2);
    a_out_ready = 1;
    tick();
    check("drain_b", a_out_data, 128'hB);
    check("drain_rdy", 128'(a_in_ready), 128'd1);
    check("drain_occ1", 128'(a_occ), 128'd1);
    tick();
    check("drain_empty", 128'(a_out_valid), 128'd0);
    check("drain_bubble", 128'(a_bubble), 128'd5);

    // 4: flush from SKID with a pending 0xC
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = 128'h1;
    tick();
    a_in_data = 128'h2;
    tick();
    check("pre_flush_occ", 128'(a_occ), 128'd2);
    a_in_data = 128'hC;
    a_flush   = 1;
    tick();
    a_flush = 0;
    a_in_valid = 0;
    check("flush_valid", 128'(a_out_valid), 128'd0);
    check("flush_occ", 128'(a_occ), 128'd0);
    check("flush_rdy", 128'(a_in_ready), 128'd1);
    check("flush_bubble", 128'(a_bubble), 128'd6);
    a_out_ready = 1;
    tick();
    tick();
    check("flush_no_c", 128'(a_out_valid), 128'd0);
    check("flush_bubble2", 128'(a_bubble), 128'd8);

    // flush from FULL while an entry is accepted: the entry is discarded
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = 128'h3;
    tick();
    a_in_data = 128'hD;
    a_flush   = 1;
    #1 check("flushf_fire", 128'(a_in_ready), 128'd1);
    tick();
    a_flush = 0;
    a_in_valid = 0;
    check("flushf_valid", 128'(a_out_valid), 128'd0);
    check("flushf_bubble", 128'(a_bubble), 128'd9);
    tick();
    check("flushf_no_d", 128'(a_out_valid), 128'd0);

    // 5: no-skid instance, combinational in_ready
    b_in_valid = 1;
    b_in_data  = 8'h44;
    #1 check("ns_rdy_empty", 128'(b_in_ready), 128'd1);
    tick();
    check("ns_d44", 128'(b_out_data), 128'h44);
    b_in_data = 8'h55;
    #1 check("ns_rdy_stall", 128'(b_in_ready), 128'd0);
    tick();
    check("ns_stable", 128'(b_out_data), 128'h44);
    check("ns_occ", 128'(b_occ), 128'd1);
    b_out_ready = 1;
    #1 check("ns_rdy_pass", 128'(b_in_ready), 128'd1);
    tick();
    b_in_valid = 0;
    check("ns_d55", 128'(b_out_data), 128'h55);
    check("ns_nobubble", 128'(b_out_valid), 128'd1);
    tick();
    check("ns_empty", 128'(b_out_valid), 128'd0);

    // 6: narrow counter saturates, then rst beats flush and in_fire
    repeat (20) tick();
    check("cnt_sat", 128'(c_bubble), 128'd15);
    c_in_valid = 1;
    c_in_data  = 8'h5A;
    tick();
    check("cnt_load", 128'(c_out_data), 128'h5A);
    check("cnt_sat_hold", 128'(c_bubble), 128'd15);
    c_in_data = 8'h77;
    c_flush   = 1;
    rst       = 1;
    tick();
    rst = 0;
    c_flush = 0;
    c_in_valid = 0;
    check("rst_c_valid", 128'(c_out_valid), 128'd0);
    check("rst_c_occ", 128'(c_occ), 128'd0);
    check("rst_c_data", 128'(c_out_data), 128'd0);
    check("rst_c_bubble", 128'(c_bubble), 128'd0);
    check("rst_c_rdy", 128'(c_in_ready), 128'd1);
    check("rst_a_bubble", 128'(a_bubble), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
